clock_reset_sequencer: RTL and testbench

//  Reset/start-up sequencer for a monitored clock domain. Takes the asynchronous

---
 rtl/clock_reset_sequencer_pkg.sv | 20 ++
 rtl/clock_reset_sequencer_if.sv | 38 +++
 rtl/clock_reset_sequencer_sync.sv | 26 ++
 rtl/clock_reset_sequencer.sv | 156 +++++++++++++++
 tb/tb_clock_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_reset_sequencer_pkg.sv
// clock_reset_sequencer_pkg
//   Shared types and helpers for the clock/reset sequencer.
//   - clkseq_state_t : sequencer FSM states
//   - clkseq_width() : register width needed to hold the count values 0..max_count-1
package clock_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } clkseq_state_t;

  // Counters compare against a terminal value and never wrap, so they only
  // need to reach max_count-1. Never narrower than one bit.
  function automatic int clkseq_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_if.sv
// clock_reset_sequencer_if
//   Bundles the sequencer's monitor inputs and reset outputs.
//   Parameters: NRST (number of reset lines), LCNT_WIDTH (loss counter width).
//   Signals:
//     detected   clock-present flag from the monitor (asynchronous)
//     restart    one-cycle pulse in the monclk domain, re-runs the sequence
//     rst_out    per-stage active-high resets, bit 0 released first
//     ready      all stages released
//     loss_count clock-loss events, only when CLKSEQ_LOSSCNT_EN is defined
//   Modports: master = sequencer side, slave = consumer/driver side.
interface clock_reset_sequencer_if #(
  parameter int NRST       = 3,
  parameter int LCNT_WIDTH = 8
);
  logic            detected;
  logic            restart;
  logic [NRST-1:0] rst_out;
  logic            ready;

  if (NRST < 1 || LCNT_WIDTH < 1) begin : g_bad_param
    $error("clock_reset_sequencer_if: NRST and LCNT_WIDTH must be >= 1");
  end

`ifdef CLKSEQ_LOSSCNT_EN
  logic [LCNT_WIDTH-1:0] loss_count;

  modport master (input detected, input restart,
                  output rst_out, output ready, output loss_count);
  modport slave  (output detected, output restart,
                  input rst_out, input ready, input loss_count);
`else
  modport master (input detected, input restart,
                  output rst_out, output ready);
  modport slave  (output detected, output restart,
                  input rst_out, input ready);
`endif

endinterface

// File: rtl/clock_reset_sequencer_sync.sv
// clkseq_sync
//   SYNC_STAGES-deep bit synchronizer with asynchronous active-high reset.
//   Ports: reset, monclk, async_in (asynchronous source), sync_out.
//   The async_in -> sync_reg[0] path must be constrained as a false path.
module clkseq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic reset,
  input  logic monclk,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge monclk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer
//   Start-up reset sequencer running on the monitored clock. Keeps all NRST
//   reset lines asserted until detected has been continuously high for
//   STABLE_CYCLES, then releases them bit 0 first, STEP_CYCLES apart, and
//   finally raises ready. Clock loss (detected low) or restart re-asserts all.
//   Ports:
//     reset   asynchronous active-high reset
//     monclk  sequencer clock (the monitored clock itself)
//     bus     clock_reset_sequencer_if.master (detected, restart, rst_out,
//             ready, and loss_count when enabled)
//   Build option: define CLKSEQ_LOSSCNT_EN to add the saturating loss counter.
module clock_reset_sequencer
  import clock_reset_sequencer_pkg::*;
#(
  parameter int NRST          = 3,
  parameter int STABLE_CYCLES = 1024,
  parameter int STEP_CYCLES   = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int LCNT_WIDTH    = 8
) (
  input  logic                            reset,
  input  logic                            monclk,
  clock_reset_sequencer_if.master         bus
);

  if (NRST < 1 || STABLE_CYCLES < 2 || STEP_CYCLES < 1 ||
      SYNC_STAGES < 2 || LCNT_WIDTH < 1) begin : g_bad_param
    $error("clock_reset_sequencer: parameter out of range");
  end

  // One counter serves both the stability wait and the release steps.
  localparam int CNT_W = clkseq_width((STABLE_CYCLES > STEP_CYCLES) ?
                                      STABLE_CYCLES : STEP_CYCLES);
  localparam int IDX_W = clkseq_width(NRST);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NRST - 1);

  logic det_s;

  clkseq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .reset    (reset),
    .monclk   (monclk),
    .async_in (bus.detected),
    .sync_out (det_s)
  );

  clkseq_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [NRST-1:0]  rst_reg, rst_next;
  logic             ready_reg, ready_next;
  logic [NRST-1:0]  step_mask;
  logic [IDX_W-1:0] idx_inc;
  logic             abort;

  assign abort   = !det_s || bus.restart;
  assign idx_inc = idx_reg + 1'b1;

  // One-hot mask selecting the reset line released at the next step.
  for (genvar gi = 0; gi < NRST; gi++) begin : g_step_mask
    assign step_mask[gi] = (idx_inc == IDX_W'(gi));
  end

  always_ff @(posedge monclk or posedge reset) begin
    if (reset) begin
      state_reg <= HOLD;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      rst_reg   <= '1;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rst_reg   <= rst_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rst_next   = rst_reg;
    ready_next = ready_reg;
    case (state_reg)
      HOLD: begin
        // restart is meaningless here: the sequence has not started.
        rst_next   = '1;
        ready_next = 1'b0;
        if (det_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end
      end
      STABLE, RELEASE, RUN: begin
        if (abort) begin
          // Abort wins over any count progress on the same edge.
          state_next = HOLD;
          cnt_next   = '0;
          rst_next   = '1;
          ready_next = 1'b0;
        end else if (state_reg == STABLE) begin
          if (cnt_reg == STABLE_LAST) begin
            state_next  = RELEASE;
            cnt_next    = '0;
            idx_next    = '0;
            rst_next[0] = 1'b0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (state_reg == RELEASE) begin
          if (cnt_reg == STEP_LAST) begin
            cnt_next = '0;
            if (idx_reg == IDX_LAST) begin
              state_next = RUN;
              ready_next = 1'b1;
            end else begin
              idx_next = idx_inc;
              rst_next = rst_reg & ~step_mask;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.rst_out = rst_reg;
  assign bus.ready   = ready_reg;

`ifdef CLKSEQ_LOSSCNT_EN
  logic [LCNT_WIDTH-1:0] loss_reg, loss_next;

  // Only a genuine clock loss out of RUN counts; restarts do not.
  always_comb begin
    loss_next = loss_reg;
    if (state_reg == RUN && !det_s && loss_reg != '1) begin
      loss_next = loss_reg + 1'b1;
    end
  end

  always_ff @(posedge monclk or posedge reset) begin
    if (reset) begin
      loss_reg <= '0;
    end else begin
      loss_reg <= loss_next;
    end
  end

  assign bus.loss_count = loss_reg;
`endif

endmodule

// File: tb/tb_clock_reset_sequencer.sv
module tb_clock_reset_sequencer;

  localparam int NRST   = 3;
  localparam int STABLE = 8;
  localparam int STEP   = 4;
  localparam int SYNC   = 2;
  localparam int LCW    = 8;

  logic reset;
  logic monclk;

  clock_reset_sequencer_if #(.NRST(NRST), .LCNT_WIDTH(LCW)) bus ();

  clock_reset_sequencer #(
    .NRST          (NRST),
    .STABLE_CYCLES (STABLE),
    .STEP_CYCLES   (STEP),
    .SYNC_STAGES   (SYNC),
    .LCNT_WIDTH    (LCW)
  ) dut (
    .reset  (reset),
    .monclk (monclk),
    .bus    (bus)
  );

  initial monclk = 1'b0;
  always #5 monclk = ~monclk;

  // Posedges of monclk since reset was released; edge 1 is the first one.
  int edge_cnt;
  always @(posedge monclk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  typedef struct {
    int         edge_no;
    logic [2:0] rst;
    logic       rdy;
  } exp_t;

  exp_t vec_tbl [9];
  exp_t exp_q [$];
  exp_t cur;
  int   n_cmp;
  int   n_bad;

  // Scoreboard: compare each queued expectation on the falling edge after
  // the rising edge it names.
  always @(negedge monclk) begin
    while (!reset && exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      cur = exp_q.pop_front();
      n_cmp++;
      if (cur.edge_no != edge_cnt || bus.rst_out !== cur.rst || bus.ready !== cur.rdy) begin
        n_bad++;
        $display("FAIL seq@%0d: rst_out=%b ready=%b at edge %0d, required rst_out=%b ready=%b",
                 cur.edge_no, bus.rst_out, bus.ready, edge_cnt, cur.rst, cur.rdy);
      end else begin
        $display("chk edge %0d: rst_out=%b ready=%b ok", edge_cnt, bus.rst_out, bus.ready);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("chk %s: %0h ok", name, act);
    end
  endtask

  // Move to just after the next falling edge (scoreboard already ran).
  task automatic step();
    @(negedge monclk);
    #1;
  endtask

  task automatic push_table(input int base);
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      e = vec_tbl[i];
      e.edge_no = e.edge_no + base;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks pending after %0d cycles, required 0", exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  task automatic wait_ready(input logic val, input int bound, output logic ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (bus.ready !== val && n < bound) begin
      step();
      n++;
    end
    if (bus.ready !== val) begin
      n_cmp++;
      n_bad++;
      ok = 1'b0;
      $display("FAIL ready_wait: ready=%b after %0d cycles, required %b", bus.ready, bound, val);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   b;
    logic ok;

    // Release timeline with detected high before edge 1 (offsets from base).
    vec_tbl[0] = '{edge_no: 2,  rst: 3'b111, rdy: 1'b0};
    vec_tbl[1] = '{edge_no: 10, rst: 3'b111, rdy: 1'b0};
    vec_tbl[2] = '{edge_no: 11, rst: 3'b110, rdy: 1'b0};
    vec_tbl[3] = '{edge_no: 14, rst: 3'b110, rdy: 1'b0};
    vec_tbl[4] = '{edge_no: 15, rst: 3'b100, rdy: 1'b0};
    vec_tbl[5] = '{edge_no: 18, rst: 3'b100, rdy: 1'b0};
    vec_tbl[6] = '{edge_no: 19, rst: 3'b000, rdy: 1'b0};
    vec_tbl[7] = '{edge_no: 22, rst: 3'b000, rdy: 1'b0};
    vec_tbl[8] = '{edge_no: 23, rst: 3'b000, rdy: 1'b1};

    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    bus.detected = 1'b0;
    bus.restart  = 1'b0;
    repeat (2) step();

    check("reset_rst_out", 32'(bus.rst_out), 32'h7);
    check("reset_ready", 32'(bus.ready), 32'h0);
`ifdef CLKSEQ_LOSSCNT_EN
    check("reset_loss", 32'(bus.loss_count), 32'h0);
`endif

    // Basic start-up sequence.
    reset        = 1'b0;
    bus.detected = 1'b1;
    push_table(edge_cnt);
    wait_drain(60);

    // Clock loss in RUN: det_s drops two edges later, abort one edge after.
    b = edge_cnt;
    bus.detected = 1'b0;
    exp_q.push_back('{edge_no: b + 2, rst: 3'b000, rdy: 1'b1});
    exp_q.push_back('{edge_no: b + 3, rst: 3'b111, rdy: 1'b0});
    wait_drain(20);
`ifdef CLKSEQ_LOSSCNT_EN
    check("loss_after_drop", 32'(bus.loss_count), 32'h1);
`endif

    // Clock returns: full sequence again.
    bus.detected = 1'b1;
    push_table(edge_cnt);
    wait_drain(60);

    // Lose the clock once more so the sync chain is empty, then glitch
    // detected low during STABLE; the count must restart from zero.
    bus.detected = 1'b0;
    repeat (4) step();
    check("loss_hold_rst_out", 32'(bus.rst_out), 32'h7);
    b = edge_cnt;
    bus.detected = 1'b1;
    repeat (5) step();
    bus.detected = 1'b0;
    repeat (3) step();
    bus.detected = 1'b1;
    push_table(b + 8);
    repeat (3) step();
    check("glitch_no_early_release", 32'(bus.rst_out), 32'h7);
    wait_drain(60);
`ifdef CLKSEQ_LOSSCNT_EN
    check("loss_stable_glitch_ignored", 32'(bus.loss_count), 32'h2);
`endif

    // Restart in RUN: resets re-asserted on the next edge, rerun follows.
    b = edge_cnt;
    push_table(b - 1);
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    wait_drain(60);
`ifdef CLKSEQ_LOSSCNT_EN
    check("loss_restart_ignored", 32'(bus.loss_count), 32'h2);
`endif

    // Asynchronous reset in the middle of RELEASE.
    b = edge_cnt;
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    for (int i = 0; i < 40 && edge_cnt < b + 15; i++) step();
    check("mid_release_rst_out", 32'(bus.rst_out), 32'h4);
    reset = 1'b1;
    #1;
    check("async_reset_rst_out", 32'(bus.rst_out), 32'h7);
    check("async_reset_ready", 32'(bus.ready), 32'h0);
`ifdef CLKSEQ_LOSSCNT_EN
    check("async_reset_loss", 32'(bus.loss_count), 32'h0);
`endif
    step();
    reset = 1'b0;
    push_table(edge_cnt);
    wait_drain(60);

`ifdef CLKSEQ_LOSSCNT_EN
    // Saturation: 260 losses on an 8-bit counter.
    for (int k = 0; k < 260; k++) begin
      bus.detected = 1'b0;
      wait_ready(1'b0, 10, ok);
      if (!ok) break;
      repeat (2) step();
      bus.detected = 1'b1;
      wait_ready(1'b1, 60, ok);
      if (!ok) break;
    end
    check("loss_saturated", 32'(bus.loss_count), 32'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
